// File: rtl/ram_pattern_loader.sv
// Fills DEPTH RAM words from BASE_ADDR through port B with a selected pattern, one word per clock; done DEPTH+1 cycles after start.
// No backpressure: start is ignored while busy. PATTERN_READBACK_EN adds a readback check (done at 2*DEPTH+2) with a sticky error flag.
module ram_pattern_loader #(
   parameter int ADDR_W    = 8,
   parameter int DEPTH     = 16,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [7:0]        fill_value,
   input  logic [7:0]        rdata,
   output logic              we,
   output logic [ADDR_W-1:0] addr,
   output logic [7:0]        wdata,
   output logic              busy,
   output logic              done,
   output logic              error
);

   typedef enum logic [2:0] {IDLE, WRITE, VERIFY, CHECK, DONE} state_t;

   localparam logic [ADDR_W:0]   LAST = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

   state_t            state;
   logic [ADDR_W:0]   idx;
   logic [1:0]        mode_q;
   logic [7:0]        fill_q;

   function automatic logic [7:0] pattern(input logic [1:0] m, input logic [7:0] f,
                                          input logic [ADDR_W:0] i);
      logic [3:0] p;
      logic [7:0] res;
      p = 4'(i % 14);
      case (m)
         2'd0:    res = 8'h01 << i[2:0];
         2'd1:    res = 8'(i);
         2'd2:    res = (p < 4'd8) ? (8'h01 << p[2:0]) : (8'h01 << 3'(4'd14 - p));
         default: res = f;
      endcase
      return res;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         idx    <= '0;
         mode_q <= 2'd0;
         fill_q <= 8'h00;
         we     <= 1'b0;
         addr   <= '0;
         wdata  <= 8'h00;
         busy   <= 1'b0;
         done   <= 1'b0;
`ifdef PATTERN_READBACK_EN
         error  <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mode_q <= mode;
                  fill_q <= fill_value;
                  idx    <= '0;
                  we     <= 1'b1;
                  addr   <= BASE;
                  wdata  <= pattern(mode, fill_value, '0);
                  busy   <= 1'b1;
                  state  <= WRITE;
`ifdef PATTERN_READBACK_EN
                  error  <= 1'b0;
`endif
               end
            end
            WRITE: begin
               if (idx == LAST) begin
                  we    <= 1'b0;
                  wdata <= 8'h00;
`ifdef PATTERN_READBACK_EN
                  idx   <= '0;
                  addr  <= BASE;
                  state <= VERIFY;
`else
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
`endif
               end else begin
                  idx   <= idx + 1'b1;
                  addr  <= addr + 1'b1;
                  wdata <= pattern(mode_q, fill_q, idx + 1'b1);
               end
            end
`ifdef PATTERN_READBACK_EN
            // rdata seen here belongs to the address presented one cycle earlier
            VERIFY: begin
               if (idx != '0 && rdata != pattern(mode_q, fill_q, idx - 1'b1))
                  error <= 1'b1;
               if (idx == LAST) begin
                  state <= CHECK;
               end else begin
                  idx  <= idx + 1'b1;
                  addr <= addr + 1'b1;
               end
            end
            CHECK: begin
               if (rdata != pattern(mode_q, fill_q, idx))
                  error <= 1'b1;
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= DONE;
            end
`endif
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifndef PATTERN_READBACK_EN
   logic unused_rdata;
   assign unused_rdata = ^rdata;
   assign error = 1'b0;
`endif

endmodule

// File: tb/tb_ram_pattern_loader.sv
// Directed bench for ram_pattern_loader: pattern table, wrap-around instance, mid-load reset and readback error flag.
module tb_ram_pattern_loader;

`ifdef PATTERN_READBACK_EN
   localparam int  LAT = 34;
   localparam logic RB = 1'b1;
`else
   localparam int  LAT = 17;
   localparam logic RB = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [1:0] mode = 2'd0;
   logic [7:0] fill_value = 8'h00;
   logic [7:0] rdata;
   logic       we, busy, done, error;
   logic [7:0] addr, wdata;

   logic       start_w = 1'b0;
   logic       we_w, busy_w, done_w, error_w;
   logic [7:0] addr_w, wdata_w;

   logic [7:0] mem [256];
   logic       corrupt = 1'b0;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ram_pattern_loader dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .fill_value(fill_value),
      .rdata(rdata), .we(we), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
      .error(error)
   );

   ram_pattern_loader #(.ADDR_W(8), .DEPTH(16), .BASE_ADDR(250)) dut_w (
      .clk(clk), .rst_n(rst_n), .start(start_w), .mode(2'd1), .fill_value(8'h00),
      .rdata(8'h00), .we(we_w), .addr(addr_w), .wdata(wdata_w), .busy(busy_w),
      .done(done_w), .error(error_w)
   );

   // RAM model: port B write plus 1-cycle registered read, optional corruption of addr 3
   always @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= (corrupt && addr == 8'd3) ? ~mem[addr] : mem[addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic do_start(input logic [1:0] m, input logic [7:0] f);
      @(negedge clk);
      mode = m;
      fill_value = f;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic run_load(input logic [1:0] m, input logic [7:0] f, input bit poke,
                           input logic [127:0] exp, input logic exp_err, input string tag);
      int n, busy_c, done_c;
      do_start(m, f);
      if (poke) fill_value = 8'h3C;
      n = 0; busy_c = 0; done_c = -1;
      for (int c = 1; c <= 100 && done_c < 0; c++) begin
         @(negedge clk);
         if (start) start = 1'b0;
         if (we) begin
            if (n < 16) begin
               chk({tag, "_addr"}, 32'(addr), 32'(n));
               chk({tag, "_wdata"}, 32'(wdata), 32'(exp[8*n +: 8]));
            end
            n++;
         end
         if (busy) busy_c++;
         if (done) begin
            done_c = c;
            chk({tag, "_error"}, 32'(error), 32'(exp_err));
         end
         if (poke && (c == 5 || done)) start = 1'b1;
      end
      chk({tag, "_nwrites"}, n, 16);
      chk({tag, "_done_lat"}, done_c, LAT);
      chk({tag, "_busy_cycles"}, busy_c, LAT - 1);
      for (int k = 0; k < 16; k++)
         chk({tag, "_readback"}, 32'(mem[k]), 32'(exp[8*k +: 8]));
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
      chk({tag, "_busy_after"}, 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      chk({tag, "_no_reload"}, 32'({busy, we}), 32'd0);
   endtask

   typedef struct {
      logic [1:0]   mode;
      logic [7:0]   fill;
      bit           poke;
      logic [127:0] exp;
      string        tag;
   } vec_t;

   vec_t vecs [4];

   initial begin
      int nw, nd;
      logic [7:0] ea;

      for (int k = 0; k < 256; k++) mem[k] = 8'h00;
      // word k lives in bits [8k+7:8k]
      vecs[0] = '{2'd1, 8'h00, 1'b0, 128'h0F0E0D0C0B0A0908_0706050403020100, "count"};
      vecs[1] = '{2'd0, 8'h00, 1'b0, 128'h8040201008040201_8040201008040201, "walk"};
      vecs[2] = '{2'd2, 8'h00, 1'b0, 128'h0201020408102040_8040201008040201, "bounce"};
      vecs[3] = '{2'd3, 8'hA5, 1'b1, {16{8'hA5}}, "fill"};

      repeat (2) @(negedge clk);
      chk("rst_we",    32'(we),    32'd0);
      chk("rst_addr",  32'(addr),  32'd0);
      chk("rst_wdata", 32'(wdata), 32'd0);
      chk("rst_busy",  32'(busy),  32'd0);
      chk("rst_done",  32'(done),  32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_w_addr", 32'(addr_w), 32'd0);
      rst_n = 1'b1;

      for (int v = 0; v < 4; v++)
         run_load(vecs[v].mode, vecs[v].fill, vecs[v].poke, vecs[v].exp, 1'b0, vecs[v].tag);

      // Mid-load reset at the 5th write cycle
      do_start(2'd1, 8'h00);
      for (int c = 1; c <= 5; c++) @(negedge clk);
      chk("mid_we_before", 32'({we, addr}), 32'h104);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_we",    32'(we),    32'd0);
      chk("mid_rst_busy",  32'(busy),  32'd0);
      chk("mid_rst_addr",  32'(addr),  32'd0);
      chk("mid_rst_wdata", 32'(wdata), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      chk("mid_mem3_kept", 32'(mem[3]), 32'h03);
      chk("mid_mem4_old",  32'(mem[4]), 32'hA5);
      run_load(2'd1, 8'h00, 1'b0, vecs[0].exp, 1'b0, "post_rst");

      // Readback: corrupted word 3 flags error only when readback is built in
      corrupt = 1'b1;
      run_load(2'd1, 8'h00, 1'b0, vecs[0].exp, RB, "rb_bad");
      corrupt = 1'b0;
      chk("rb_err_held", 32'(error), 32'(RB));
      run_load(2'd1, 8'h00, 1'b0, vecs[0].exp, 1'b0, "rb_clean");

      // Wrap-around instance: 250..255 then 0..9
      @(negedge clk);
      start_w = 1'b1;
      @(posedge clk);
      #1 start_w = 1'b0;
      nw = 0; nd = 0;
      for (int c = 1; c <= 45; c++) begin
         @(negedge clk);
         if (we_w) begin
            ea = 8'(250 + nw);
            chk("wrap_addr", 32'(addr_w), 32'(ea));
            chk("wrap_wdata", 32'(wdata_w), 32'(nw));
            nw++;
         end
         if (done_w) begin
            nd++;
            chk("wrap_busy_at_done", 32'(busy_w), 32'd0);
         end
      end
      chk("wrap_nwrites", nw, 16);
      chk("wrap_ndone", nd, 1);
      chk("wrap_error", 32'(error_w), 32'(RB));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
